// File: rtl/harpoon_ctrl_if.sv
// Pop channel between the harpoon controller (master) and the ball manager (slave).
interface harpoon_ctrl_if;
    logic       pop_valid;
    logic       pop_ready;
    logic [2:0] pop_idx;
    logic [1:0] pop_player;

    modport master (output pop_valid, output pop_idx, output pop_player, input pop_ready);
    modport slave  (input pop_valid, input pop_idx, input pop_player, output pop_ready);
endinterface

// File: rtl/harpoon_ctrl.sv
// Harpoon lifecycle sequencer for both players plus a round-robin arbiter onto one pop channel.
// Define HARPOON_STICKY_EN to enable the sticky top-of-screen HOLD phase.
module harpoon_ctrl #(
    parameter int SPEED        = 5,
    parameter int Y_MIN        = 0,
    parameter int X_OFFSET     = 20,
    parameter int STICK_FRAMES = 120,
    parameter int COOL_FRAMES  = 8
) (
    input  logic           frame_clk,
    input  logic           Reset,
    input  logic [1:0]     game_on,
    input  logic           fire_p1,
    input  logic           fire_p2,
    input  logic [9:0]     p1_x,
    input  logic [9:0]     p2_x,
    input  logic [9:0]     player_y,
    input  logic           sticky_p1,
    input  logic           sticky_p2,
    input  logic [5:0]     hit_p1,
    input  logic [5:0]     hit_p2,
    harpoon_ctrl_if.master pop,
    output logic [9:0]     b1_x,
    output logic [9:0]     b1_y,
    output logic [9:0]     b2_x,
    output logic [9:0]     b2_y,
    output logic           b1_active,
    output logic           b2_active
);
    typedef enum logic [1:0] {IDLE, RISE, HOLD, COOL} shot_state_t;

    localparam int CNT_MAX = (STICK_FRAMES > COOL_FRAMES) ? STICK_FRAMES : COOL_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [9:0]       TOP_Y      = 10'(Y_MIN);
    localparam logic [9:0]       RISE_LIMIT = 10'(Y_MIN + SPEED);
    localparam logic [9:0]       STEP       = 10'(SPEED);
    localparam logic [9:0]       X_ADD      = 10'(X_OFFSET);
    localparam logic [CNT_W-1:0] COOL_CNT   = CNT_W'(COOL_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    shot_state_t      st_q [2], st_d [2];
    logic [9:0]       bx_q [2], bx_d [2];
    logic [9:0]       by_q [2], by_d [2];
    logic [CNT_W-1:0] cnt_q [2], cnt_d [2];
    logic             fire_prev_q [2], fire_prev_d [2];
    logic             slot_v_q [2], slot_v_d [2];
    logic [2:0]       slot_idx_q [2], slot_idx_d [2];
    logic             rr_p2_q, rr_p2_d;
    logic             pop_valid_q, pop_valid_d;
    logic [2:0]       pop_idx_q, pop_idx_d;
    logic [1:0]       pop_player_q, pop_player_d;

    logic             fire [2];
    logic [9:0]       px [2];
    logic [5:0]       hit [2];
    logic             cap [2];
    logic             playing;
    logic             transfer;

    assign fire[0] = fire_p1;
    assign fire[1] = fire_p2;
    assign px[0]   = p1_x;
    assign px[1]   = p2_x;
    assign hit[0]  = hit_p1;
    assign hit[1]  = hit_p2;
    assign playing = (game_on == 2'd1);

`ifdef HARPOON_STICKY_EN
    localparam logic [CNT_W-1:0] STICK_CNT = CNT_W'(STICK_FRAMES);
    logic sticky [2];
    assign sticky[0] = sticky_p1;
    assign sticky[1] = sticky_p2;
`else
    logic unused_sticky;
    assign unused_sticky = sticky_p1 ^ sticky_p2;
`endif

    function automatic logic [2:0] lowest_set(input logic [5:0] v);
        lowest_set = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        transfer     = pop_valid_q & pop.pop_ready;
        rr_p2_d      = rr_p2_q;
        pop_valid_d  = 1'b0;
        pop_idx_d    = '0;
        pop_player_d = '0;
        for (int p = 0; p < 2; p++) begin
            st_d[p]        = st_q[p];
            bx_d[p]        = bx_q[p];
            by_d[p]        = by_q[p];
            cnt_d[p]       = cnt_q[p];
            fire_prev_d[p] = fire[p];
            cap[p]         = 1'b0;
            slot_v_d[p]    = slot_v_q[p] & ~(transfer & (pop_player_q == 2'(p + 1)));
            slot_idx_d[p]  = slot_idx_q[p];
            case (st_q[p])
                IDLE: begin
                    bx_d[p] = px[p];
                    by_d[p] = player_y;
                    // A fire edge while this player's pop is still waiting is dropped.
                    if (fire[p] && !fire_prev_q[p] && !slot_v_q[p]) begin
                        st_d[p] = RISE;
                        bx_d[p] = px[p] + X_ADD;
                    end
                end
                RISE: begin
                    if (hit[p] != 6'd0) begin
                        cap[p]   = 1'b1;
                        st_d[p]  = COOL;
                        cnt_d[p] = COOL_CNT;
                    end else if (by_q[p] <= RISE_LIMIT) begin
                        by_d[p]  = TOP_Y;
                        st_d[p]  = COOL;
                        cnt_d[p] = COOL_CNT;
`ifdef HARPOON_STICKY_EN
                        if (sticky[p]) begin
                            st_d[p]  = HOLD;
                            cnt_d[p] = STICK_CNT;
                        end
`endif
                    end else begin
                        by_d[p] = by_q[p] - STEP;
                    end
                end
                HOLD: begin
                    by_d[p] = TOP_Y;
                    if (hit[p] != 6'd0) begin
                        cap[p]   = 1'b1;
                        st_d[p]  = COOL;
                        cnt_d[p] = COOL_CNT;
                    end else if (cnt_q[p] <= CNT_ONE) begin
                        st_d[p]  = COOL;
                        cnt_d[p] = COOL_CNT;
                    end else begin
                        cnt_d[p] = cnt_q[p] - CNT_ONE;
                    end
                end
                COOL: begin
                    if (cnt_q[p] <= CNT_ONE) begin
                        st_d[p]  = IDLE;
                        cnt_d[p] = '0;
                        bx_d[p]  = px[p];
                        by_d[p]  = player_y;
                    end else begin
                        cnt_d[p] = cnt_q[p] - CNT_ONE;
                    end
                end
                default: st_d[p] = IDLE;
            endcase
            if (cap[p]) begin
                slot_v_d[p]   = 1'b1;
                slot_idx_d[p] = lowest_set(hit[p]);
            end
        end

        // After granting player 1 the pointer prefers player 2, and vice versa.
        if (transfer) rr_p2_d = (pop_player_q == 2'd1);

        pop_valid_d = slot_v_d[0] | slot_v_d[1];
        if (pop_valid_q && !pop.pop_ready) begin
            pop_idx_d    = pop_idx_q;
            pop_player_d = pop_player_q;
        end else if (slot_v_d[0] && (!slot_v_d[1] || !rr_p2_d)) begin
            pop_idx_d    = slot_idx_d[0];
            pop_player_d = 2'd1;
        end else if (slot_v_d[1]) begin
            pop_idx_d    = slot_idx_d[1];
            pop_player_d = 2'd2;
        end

        if (!playing) begin
            for (int p = 0; p < 2; p++) begin
                st_d[p]        = IDLE;
                bx_d[p]        = px[p];
                by_d[p]        = player_y;
                cnt_d[p]       = '0;
                fire_prev_d[p] = 1'b0;
                slot_v_d[p]    = 1'b0;
                slot_idx_d[p]  = '0;
            end
            rr_p2_d      = 1'b0;
            pop_valid_d  = 1'b0;
            pop_idx_d    = '0;
            pop_player_d = '0;
        end
    end

    always_ff @(posedge frame_clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of order.
        if (Reset) begin
            for (int p = 0; p < 2; p++) begin
                st_q[p]        <= IDLE;
                bx_q[p]        <= px[p];
                by_q[p]        <= player_y;
                cnt_q[p]       <= '0;
                fire_prev_q[p] <= 1'b0;
                slot_v_q[p]    <= 1'b0;
                slot_idx_q[p]  <= '0;
            end
            rr_p2_q      <= 1'b0;
            pop_valid_q  <= 1'b0;
            pop_idx_q    <= '0;
            pop_player_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                st_q[p]        <= st_d[p];
                bx_q[p]        <= bx_d[p];
                by_q[p]        <= by_d[p];
                cnt_q[p]       <= cnt_d[p];
                fire_prev_q[p] <= fire_prev_d[p];
                slot_v_q[p]    <= slot_v_d[p];
                slot_idx_q[p]  <= slot_idx_d[p];
            end
            rr_p2_q      <= rr_p2_d;
            pop_valid_q  <= pop_valid_d;
            pop_idx_q    <= pop_idx_d;
            pop_player_q <= pop_player_d;
        end
    end

    assign b1_x           = bx_q[0];
    assign b1_y           = by_q[0];
    assign b2_x           = bx_q[1];
    assign b2_y           = by_q[1];
    assign b1_active      = (st_q[0] == RISE) || (st_q[0] == HOLD);
    assign b2_active      = (st_q[1] == RISE) || (st_q[1] == HOLD);
    assign pop.pop_valid  = pop_valid_q;
    assign pop.pop_idx    = pop_idx_q;
    assign pop.pop_player = pop_player_q;
endmodule

// File: tb/tb_harpoon_ctrl.sv
// Randomized scoreboard bench for harpoon_ctrl: shot-timeline reference model plus pop-order queue.
module tb_harpoon_ctrl;
    localparam int SPEED        = 5;
    localparam int Y_MIN        = 0;
    localparam int X_OFFSET     = 20;
    localparam int STICK_FRAMES = 120;
    localparam int COOL_FRAMES  = 8;
    localparam int NEVER        = 32'h3fff_ffff;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [1:0] game_on   = 2'd0;
    logic       fire_p1   = 1'b0;
    logic       fire_p2   = 1'b0;
    logic [9:0] p1_x      = 10'd100;
    logic [9:0] p2_x      = 10'd300;
    logic [9:0] player_y  = 10'd398;
    logic       sticky_p1 = 1'b0;
    logic       sticky_p2 = 1'b0;
    logic [5:0] hit_p1    = 6'd0;
    logic [5:0] hit_p2    = 6'd0;
    logic [9:0] b1_x, b1_y, b2_x, b2_y;
    logic       b1_active, b2_active;

    harpoon_ctrl_if pop_if ();

    harpoon_ctrl #(
        .SPEED(SPEED), .Y_MIN(Y_MIN), .X_OFFSET(X_OFFSET),
        .STICK_FRAMES(STICK_FRAMES), .COOL_FRAMES(COOL_FRAMES)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .game_on(game_on),
        .fire_p1(fire_p1), .fire_p2(fire_p2), .p1_x(p1_x), .p2_x(p2_x),
        .player_y(player_y), .sticky_p1(sticky_p1), .sticky_p2(sticky_p2),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .pop(pop_if),
        .b1_x(b1_x), .b1_y(b1_y), .b2_x(b2_x), .b2_y(b2_y),
        .b1_active(b1_active), .b2_active(b2_active)
    );

    always #5 frame_clk = ~frame_clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors = vectors + 1;
        if (got !== want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] player;
        logic [2:0] idx;
    } pop_t;

    pop_t sb[$];
    int   frame_no = 0;
    bit   shot_on [2];
    int   shot_start [2], shot_y0 [2], shot_x0 [2], rise_len [2], act_end [2], cool_y [2];
    bit   m_fire_prev [2];
    bit   pend_v [2];
    int   pend_idx [2];
    int   presented    = 0;
    int   last_granted = 2;
    bit   exp_act [2];
    int   exp_x [2], exp_y [2];
    bit   exp_pv = 1'b0;

    function automatic int first_hit(input logic [5:0] h);
        for (int i = 0; i < 6; i++) if (h[i]) return i;
        return 0;
    endfunction

    // Tip height of a shot fired at height y0 on frame start, seen on frame f.
    function automatic int tip_y(input int y0, input int start, input int rl, input int f);
        int e;
        e = f - start;
        return (e < rl) ? y0 - SPEED * e : Y_MIN;
    endfunction

    always @(posedge frame_clk) begin
        bit         fire_s [2];
        bit         stk_s [2];
        bit         pend_before [2];
        int         px_s [2];
        logic [5:0] hit_s [2];
        bit         fire_evt;
        frame_no  = frame_no + 1;
        fire_s[0] = fire_p1;
        fire_s[1] = fire_p2;
        px_s[0]   = int'(p1_x);
        px_s[1]   = int'(p2_x);
        hit_s[0]  = hit_p1;
        hit_s[1]  = hit_p2;
`ifdef HARPOON_STICKY_EN
        stk_s[0] = sticky_p1;
        stk_s[1] = sticky_p2;
`else
        stk_s[0] = 1'b0;
        stk_s[1] = 1'b0;
`endif
        if (Reset || game_on != 2'd1) begin
            for (int p = 0; p < 2; p++) begin
                shot_on[p]     = 1'b0;
                m_fire_prev[p] = 1'b0;
                pend_v[p]      = 1'b0;
                exp_act[p]     = 1'b0;
                exp_x[p]       = px_s[p];
                exp_y[p]       = int'(player_y);
            end
            presented    = 0;
            last_granted = 2;
            sb.delete();
            exp_pv = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) pend_before[p] = pend_v[p];
            if (presented != 0 && pop_if.pop_ready) begin
                pend_v[presented - 1] = 1'b0;
                last_granted = presented;
                presented = 0;
            end
            for (int p = 0; p < 2; p++) begin
                fire_evt       = fire_s[p] && !m_fire_prev[p];
                m_fire_prev[p] = fire_s[p];
                if (shot_on[p]) begin
                    if (frame_no - 1 < act_end[p]) begin
                        if (hit_s[p] != 6'd0) begin
                            act_end[p]  = frame_no;
                            cool_y[p]   = tip_y(shot_y0[p], shot_start[p], rise_len[p], frame_no - 1);
                            pend_v[p]   = 1'b1;
                            pend_idx[p] = first_hit(hit_s[p]);
                        end else if (act_end[p] == NEVER &&
                                     frame_no - 1 - shot_start[p] == rise_len[p] - 1) begin
                            act_end[p] = frame_no + (stk_s[p] ? STICK_FRAMES : 0);
                            cool_y[p]  = Y_MIN;
                        end
                    end else if (frame_no >= act_end[p] + COOL_FRAMES) begin
                        shot_on[p] = 1'b0;
                    end
                end else if (fire_evt && !pend_before[p]) begin
                    shot_on[p]    = 1'b1;
                    shot_start[p] = frame_no;
                    shot_y0[p]    = int'(player_y);
                    shot_x0[p]    = (px_s[p] + X_OFFSET) % 1024;
                    act_end[p]    = NEVER;
                    rise_len[p]   = (shot_y0[p] <= Y_MIN + SPEED) ? 1 :
                                    (shot_y0[p] - Y_MIN - 1) / SPEED + 1;
                end
                if (!shot_on[p]) begin
                    exp_act[p] = 1'b0;
                    exp_x[p]   = px_s[p];
                    exp_y[p]   = int'(player_y);
                end else if (frame_no < act_end[p]) begin
                    exp_act[p] = 1'b1;
                    exp_x[p]   = shot_x0[p];
                    exp_y[p]   = tip_y(shot_y0[p], shot_start[p], rise_len[p], frame_no);
                end else begin
                    exp_act[p] = 1'b0;
                    exp_x[p]   = shot_x0[p];
                    exp_y[p]   = cool_y[p];
                end
            end
            if (presented == 0) begin
                pop_t e;
                if (pend_v[0] && pend_v[1]) presented = (last_granted == 1) ? 2 : 1;
                else if (pend_v[0])         presented = 1;
                else if (pend_v[1])         presented = 2;
                if (presented != 0) begin
                    e.player = 2'(presented);
                    e.idx    = 3'(pend_idx[presented - 1]);
                    sb.push_back(e);
                end
            end
            exp_pv = (presented != 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge frame_clk) begin
        if (frame_no > 0) begin
            check("b1_tip", {11'd0, b1_active, b1_x, b1_y},
                  {11'd0, exp_act[0], 10'(exp_x[0]), 10'(exp_y[0])});
            check("b2_tip", {11'd0, b2_active, b2_x, b2_y},
                  {11'd0, exp_act[1], 10'(exp_x[1]), 10'(exp_y[1])});
            check("pop_valid", {31'd0, pop_if.pop_valid}, {31'd0, exp_pv});
            if (pop_if.pop_valid && sb.size() != 0) begin
                check("pop_fields", {27'd0, pop_if.pop_player, pop_if.pop_idx},
                      {27'd0, sb[0].player, sb[0].idx});
                if (pop_if.pop_ready) void'(sb.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge frame_clk);
            #2;
        end
    endtask

    initial begin
        pop_if.pop_ready = 1'b1;
        step(3);
        check("reset_outputs", {23'd0, b1_active, b2_active, pop_if.pop_valid,
                                pop_if.pop_player, pop_if.pop_idx}, 32'd0);
        Reset   = 1'b0;
        game_on = 2'd1;
        step(2);

        // Single shot from 398: latched X, full rise, cooldown, back to idle.
        fire_p1 = 1'b1;
        step();
        fire_p1 = 1'b0;
        check("fire_latency", {11'd0, b1_active, b1_x, b1_y}, {11'd0, 1'b1, 10'd120, 10'd398});
        step(100);

        // Held key fires once; a release and re-press fires again.
        fire_p1 = 1'b1;
        step(300);
        check("held_single_shot", {31'd0, b1_active}, 32'd0);
        fire_p1 = 1'b0;
        step(2);
        fire_p1 = 1'b1;
        step();
        check("repress_fires", {31'd0, b1_active}, 32'd1);
        fire_p1 = 1'b0;
        step(100);

`ifdef HARPOON_STICKY_EN
        sticky_p1 = 1'b1;
        fire_p1   = 1'b1;
        step();
        fire_p1 = 1'b0;
        step(150);
        check("sticky_hold", {21'd0, b1_active, b1_y}, {21'd0, 1'b1, 10'd0});
        sticky_p1 = 1'b0;
        step(80);
`endif

        // Simultaneous hits: player 1 first, then player 2, on consecutive frames.
        fire_p1 = 1'b1;
        fire_p2 = 1'b1;
        step();
        fire_p1 = 1'b0;
        fire_p2 = 1'b0;
        step(5);
        hit_p1 = 6'b001100;
        hit_p2 = 6'b000001;
        step();
        hit_p1 = 6'd0;
        hit_p2 = 6'd0;
        check("rr_first", {26'd0, pop_if.pop_valid, pop_if.pop_player, pop_if.pop_idx},
              {26'd0, 1'b1, 2'd1, 3'd2});
        step();
        check("rr_second", {26'd0, pop_if.pop_valid, pop_if.pop_player, pop_if.pop_idx},
              {26'd0, 1'b1, 2'd2, 3'd0});
        step(20);

        // Back-pressure: slot stays full, a new fire edge is dropped.
        fire_p1 = 1'b1;
        step();
        fire_p1 = 1'b0;
        step(3);
        pop_if.pop_ready = 1'b0;
        hit_p1 = 6'b100000;
        step();
        hit_p1 = 6'd0;
        step(10);
        fire_p1 = 1'b1;
        step();
        fire_p1 = 1'b0;
        check("fire_dropped_while_pending", {31'd0, b1_active}, 32'd0);
        step(2);
        pop_if.pop_ready = 1'b1;
        step(3);

        // Game stops mid-rise.
        player_y = 10'd400;
        fire_p1  = 1'b1;
        step();
        fire_p1 = 1'b0;
        for (int i = 0; i < 200 && b1_y != 10'd200; i++) step();
        check("reach_y200", {22'd0, b1_y}, 32'd200);
        game_on = 2'd0;
        step();
        check("game_off", {20'd0, b1_active, pop_if.pop_valid, b1_y},
              {20'd0, 1'b0, 1'b0, 10'd400});
        game_on = 2'd1;
        step(3);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fire_p1 = ~fire_p1;
            if ($urandom_range(0, 3) == 0) fire_p2 = ~fire_p2;
            if ($urandom_range(0, 49) == 0) p1_x = 10'($urandom);
            if ($urandom_range(0, 49) == 0) p2_x = 10'($urandom);
            if ($urandom_range(0, 99) == 0) player_y = 10'($urandom_range(0, 479));
            sticky_p1 = 1'($urandom_range(0, 1));
            sticky_p2 = 1'($urandom_range(0, 1));
            hit_p1 = ($urandom_range(0, 14) == 0) ? 6'($urandom) : 6'd0;
            hit_p2 = ($urandom_range(0, 14) == 0) ? 6'($urandom) : 6'd0;
            pop_if.pop_ready = ($urandom_range(0, 9) < 6);
            game_on = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            if ($urandom_range(0, 999) == 0) Reset = 1'b1;
            else Reset = 1'b0;
            step();
        end

        Reset   = 1'b0;
        game_on = 2'd1;
        hit_p1  = 6'd0;
        hit_p2  = 6'd0;
        pop_if.pop_ready = 1'b1;
        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
